// File: rtl/ras_stack.sv
// -----------------------------------------------------------------------------
// ras_stack -- return-address stack for branch prediction
//
// Holds DEPTH {valid, addr} entries with entry 0 as the top of stack. A push
// shifts everything down one place (the bottom entry falls off on overflow); a
// pop shifts everything up one place and fills the bottom with an empty entry.
// A simultaneous push and pop replaces the top entry in place. The top-of-stack
// outputs come straight from the entry 0 registers.
//
// Optional feature (macro RAS_STAT_CNT_EN): saturating 16-bit overflow and
// underflow event counters, cleared only by reset.
//
// Parameters:
//   DEPTH      number of return-address entries (1..16)
//   VLEN       return-address width in bits
// Ports:
//   clk_i      clock, all state updates on the rising edge
//   rst_i      synchronous active-high reset
//   flush_bp_i invalidate all entries (wins over push/pop)
//   push_i     push data_i (call predicted)
//   pop_i      pop top entry (return predicted)
//   data_i     return address to push
//   valid_o    top entry valid
//   ra_o       top entry address
//   count_o    number of valid entries
//   ovf_cnt_o  overflow event count   (RAS_STAT_CNT_EN only)
//   unf_cnt_o  underflow event count  (RAS_STAT_CNT_EN only)
// -----------------------------------------------------------------------------
module ras_stack #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned VLEN  = 64,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_bp_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] data_i,
    output logic            valid_o,
    output logic [VLEN-1:0] ra_o,
    output logic [CW-1:0]   count_o
`ifdef RAS_STAT_CNT_EN
    ,
    output logic [15:0]     ovf_cnt_o,
    output logic [15:0]     unf_cnt_o
`endif
);

    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic            valid_q [DEPTH];
    logic [VLEN-1:0] addr_q  [DEPTH];
    logic [CW-1:0]   count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
            end
            count_q <= '0;
        end else if (flush_bp_i) begin
            // Addresses are left in place; with every valid bit clear they are
            // unobservable as stack content.
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
            count_q <= '0;
        end else if (push_i && pop_i) begin
            // Return immediately followed by a call: replace top, no shift.
            valid_q[0] <= 1'b1;
            addr_q[0]  <= data_i;
            if (count_q == '0) begin
                count_q <= CW'(1);
            end
        end else if (push_i) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                valid_q[i] <= valid_q[i-1];
                addr_q[i]  <= addr_q[i-1];
            end
            valid_q[0] <= 1'b1;
            addr_q[0]  <= data_i;
            if (count_q != FULL) begin
                count_q <= count_q + CW'(1);
            end
        end else if (pop_i) begin
            // On underflow every entry is already invalid, so the shift keeps
            // them invalid and the count simply stays at zero.
            for (int i = 0; i < DEPTH - 1; i++) begin
                valid_q[i] <= valid_q[i+1];
                addr_q[i]  <= addr_q[i+1];
            end
            valid_q[DEPTH-1] <= 1'b0;
            addr_q[DEPTH-1]  <= '0;
            if (count_q != '0) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign valid_o = valid_q[0];
    assign ra_o    = addr_q[0];
    assign count_o = count_q;

`ifdef RAS_STAT_CNT_EN
    logic       ovf_evt;
    logic       unf_evt;
    logic [15:0] ovf_cnt_q;
    logic [15:0] unf_cnt_q;

    assign ovf_evt = !flush_bp_i && push_i && !pop_i && (count_q == FULL);
    assign unf_evt = !flush_bp_i && pop_i && !push_i && (count_q == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            if (ovf_evt && (ovf_cnt_q != 16'hFFFF)) begin
                ovf_cnt_q <= ovf_cnt_q + 16'd1;
            end
            if (unf_evt && (unf_cnt_q != 16'hFFFF)) begin
                unf_cnt_q <= unf_cnt_q + 16'd1;
            end
        end
    end

    assign ovf_cnt_o = ovf_cnt_q;
    assign unf_cnt_o = unf_cnt_q;
`endif

endmodule

// File: tb/tb_ras_stack.sv
// -----------------------------------------------------------------------------
// tb_ras_stack -- self-checking bench for ras_stack (DEPTH=2, VLEN=64)
//
// A directed vector table covers reset, push/pop, overflow, underflow,
// simultaneous push+pop, flush and reset-over-push. A random phase follows,
// with expectations produced by a small queue model. Expected results are
// queued when stimulus is driven and popped when the DUT output is sampled.
// Build with RAS_STAT_CNT_EN defined to also check the event counters.
// -----------------------------------------------------------------------------
module tb_ras_stack;

    localparam int DEPTH = 2;
    localparam int VLEN  = 64;

    logic            clk_i = 1'b0;
    logic            rst_i;
    logic            flush_bp_i;
    logic            push_i;
    logic            pop_i;
    logic [VLEN-1:0] data_i;
    logic            valid_o;
    logic [VLEN-1:0] ra_o;
    logic [1:0]      count_o;
`ifdef RAS_STAT_CNT_EN
    logic [15:0]     ovf_cnt_o;
    logic [15:0]     unf_cnt_o;
`endif

    ras_stack #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_bp_i (flush_bp_i),
        .push_i     (push_i),
        .pop_i      (pop_i),
        .data_i     (data_i),
        .valid_o    (valid_o),
        .ra_o       (ra_o),
        .count_o    (count_o)
`ifdef RAS_STAT_CNT_EN
        ,
        .ovf_cnt_o  (ovf_cnt_o),
        .unf_cnt_o  (unf_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic            v;
        logic [VLEN-1:0] ra;
        logic            chk_ra;
        logic [1:0]      c;
        logic [15:0]     ovf;
        logic [15:0]     unf;
    } exp_t;

    typedef struct {
        logic            rst;
        logic            flush;
        logic            push;
        logic            pop;
        logic [VLEN-1:0] data;
        exp_t            e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst, input logic flush, input logic push,
                       input logic pop, input logic [VLEN-1:0] data,
                       input logic v, input logic [VLEN-1:0] ra, input logic chk_ra,
                       input logic [1:0] c, input logic [15:0] ovf, input logic [15:0] unf);
        vec_t t;
        t.rst = rst; t.flush = flush; t.push = push; t.pop = pop; t.data = data;
        t.e.v = v; t.e.ra = ra; t.e.chk_ra = chk_ra; t.e.c = c;
        t.e.ovf = ovf; t.e.unf = unf;
        vecs.push_back(t);
    endtask

    // Drive one cycle of stimulus (called after a falling edge), queue its
    // expectation, then sample just after the rising edge and compare.
    task automatic step(input string tag, input logic rst, input logic flush,
                        input logic push, input logic pop,
                        input logic [VLEN-1:0] data, input exp_t e);
        exp_t x;
        rst_i = rst; flush_bp_i = flush; push_i = push; pop_i = pop; data_i = data;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        x = sb.pop_front();
        checks++;
        if (valid_o !== x.v) begin
            errors++;
            $display("FAIL %s valid_o: got %0b expected %0b", tag, valid_o, x.v);
        end
        checks++;
        if (count_o !== x.c) begin
            errors++;
            $display("FAIL %s count_o: got %0d expected %0d", tag, count_o, x.c);
        end
        if (x.chk_ra) begin
            checks++;
            if (ra_o !== x.ra) begin
                errors++;
                $display("FAIL %s ra_o: got %h expected %h", tag, ra_o, x.ra);
            end
        end
`ifdef RAS_STAT_CNT_EN
        checks++;
        if (ovf_cnt_o !== x.ovf) begin
            errors++;
            $display("FAIL %s ovf_cnt_o: got %0d expected %0d", tag, ovf_cnt_o, x.ovf);
        end
        checks++;
        if (unf_cnt_o !== x.unf) begin
            errors++;
            $display("FAIL %s unf_cnt_o: got %0d expected %0d", tag, unf_cnt_o, x.unf);
        end
`endif
        @(negedge clk_i);
    endtask

    // Reference model for the random phase: index 0 is top of stack.
    logic [VLEN-1:0] mq[$];
    logic [15:0]     m_ovf;
    logic [15:0]     m_unf;

    initial begin
        exp_t e;
        //   rst flush push pop data          v  ra             chk c  ovf unf
        add(1, 0, 0, 0, 64'h0,           0, 64'h0,           1, 0, 0, 0);
        add(0, 0, 1, 0, 64'h8000_0010,   1, 64'h8000_0010,   1, 1, 0, 0);
        add(1, 0, 0, 0, 64'h0,           0, 64'h0,           1, 0, 0, 0);
        add(0, 0, 1, 0, 64'h100,         1, 64'h100,         1, 1, 0, 0);
        add(0, 0, 1, 0, 64'h200,         1, 64'h200,         1, 2, 0, 0);
        add(0, 0, 1, 0, 64'h300,         1, 64'h300,         1, 2, 1, 0);
        add(0, 0, 0, 1, 64'h0,           1, 64'h200,         1, 1, 1, 0);
        add(0, 0, 0, 1, 64'h0,           0, 64'h0,           1, 0, 1, 0);
        add(0, 0, 0, 1, 64'h0,           0, 64'h0,           1, 0, 1, 1);
        add(0, 0, 0, 1, 64'h0,           0, 64'h0,           1, 0, 1, 2);
        add(0, 0, 0, 1, 64'h0,           0, 64'h0,           1, 0, 1, 3);
        add(0, 0, 0, 0, 64'h0,           0, 64'h0,           1, 0, 1, 3);
        add(0, 0, 1, 0, 64'h100,         1, 64'h100,         1, 1, 1, 3);
        add(0, 0, 1, 0, 64'h200,         1, 64'h200,         1, 2, 1, 3);
        add(0, 0, 1, 1, 64'h400,         1, 64'h400,         1, 2, 1, 3);
        add(0, 0, 0, 1, 64'h0,           1, 64'h100,         1, 1, 1, 3);
        add(0, 0, 1, 0, 64'h200,         1, 64'h200,         1, 2, 1, 3);
        add(0, 1, 1, 0, 64'h500,         0, 64'h0,           0, 0, 1, 3);
        add(0, 0, 0, 0, 64'h0,           0, 64'h0,           0, 0, 1, 3);
        add(0, 0, 1, 0, 64'h600,         1, 64'h600,         1, 1, 1, 3);
        add(0, 0, 1, 0, 64'h700,         1, 64'h700,         1, 2, 1, 3);
        add(1, 0, 1, 0, 64'h800,         0, 64'h0,           1, 0, 0, 0);
        add(0, 0, 0, 0, 64'h0,           0, 64'h0,           1, 0, 0, 0);
        add(0, 0, 1, 1, 64'h900,         1, 64'h900,         1, 1, 0, 0);
        add(0, 0, 0, 0, 64'h0,           1, 64'h900,         1, 1, 0, 0);

        rst_i = 1'b1; flush_bp_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; data_i = '0;
        @(negedge clk_i);

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].flush,
                 vecs[i].push, vecs[i].pop, vecs[i].data, vecs[i].e);
        end

        // Random phase, continuing from the table's final state {0x900}.
        mq.delete();
        mq.push_back(64'h900);
        m_ovf = 16'd0;
        m_unf = 16'd0;
        for (int n = 0; n < 400; n++) begin
            int              op;
            logic            f, pu, po;
            logic [VLEN-1:0] d;
            op = int'($urandom_range(0, 9));
            d  = {$urandom, $urandom};
            f  = (op == 0);
            pu = (op >= 1 && op <= 4) || (op == 8);
            po = (op >= 5 && op <= 7) || (op == 8);
            if (f) begin
                mq.delete();
            end else if (pu && po) begin
                if (mq.size() == 0) mq.push_front(d);
                else mq[0] = d;
            end else if (pu) begin
                mq.push_front(d);
                if (mq.size() > DEPTH) begin
                    void'(mq.pop_back());
                    if (m_ovf != 16'hFFFF) m_ovf++;
                end
            end else if (po) begin
                if (mq.size() == 0) begin
                    if (m_unf != 16'hFFFF) m_unf++;
                end else begin
                    void'(mq.pop_front());
                end
            end
            e.v      = (mq.size() > 0);
            e.ra     = (mq.size() > 0) ? mq[0] : '0;
            e.chk_ra = (mq.size() > 0);
            e.c      = 2'(mq.size());
            e.ovf    = m_ovf;
            e.unf    = m_unf;
            step($sformatf("rnd%0d", n), 1'b0, f, pu, po, d, e);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
